piso_serial_tx: RTL and testbench

Parallel-in, serial-out frame transmitter, the driving end of a single-wire serial link. A producer hands it one word via a valid/ready handshake. The block serialises the word as a frame: start bit (0), DATA_W data bits LSB first, then a stop bit (1). Each bit is held for CLKS_PER_BIT clock cycles. The block sits between a register-level producer and the link's line driver; the matching sampler/receiver sits on the far end of the wire.

---
 rtl/piso_serial_tx.sv | 159 +++++++++++++++
 tb/tb_piso_serial_tx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serial_tx.sv
// Parallel-in serial-out frame transmitter: start bit, DATA_W bits LSB first, optional parity, stop bit.
// Optional even-parity bit between data and stop is enabled by defining PIS_PARITY_EN.
module piso_serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_serial,
  output logic              tx_busy,
  output logic              tx_done
);

  // Handshake: a word transfers on a rising clk edge where tx_valid && tx_ready;
  // tx_ready depends only on registered state and rst, never on tx_valid.

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);

`ifdef PIS_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t            state, state_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [BW-1:0]     bit_cnt, bit_cnt_n;
  logic              serial_n, busy_n, done_n;
  logic              bit_end;
`ifdef PIS_PARITY_EN
  logic              parity, parity_n;
`endif

  assign tx_ready = (state == S_IDLE) && !rst;
  assign bit_end  = (cnt == C_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      shreg     <= '0;
      cnt       <= '0;
      bit_cnt   <= '0;
      tx_serial <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
`ifdef PIS_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      cnt       <= cnt_n;
      bit_cnt   <= bit_cnt_n;
      tx_serial <= serial_n;
      tx_busy   <= busy_n;
      tx_done   <= done_n;
`ifdef PIS_PARITY_EN
      parity    <= parity_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    cnt_n     = cnt;
    bit_cnt_n = bit_cnt;
    serial_n  = tx_serial;
    busy_n    = tx_busy;
    done_n    = 1'b0;
`ifdef PIS_PARITY_EN
    parity_n  = parity;
`endif
    unique case (state)
      S_IDLE: begin
        serial_n  = 1'b1;
        busy_n    = 1'b0;
        cnt_n     = '0;
        bit_cnt_n = '0;
        if (tx_valid && tx_ready) begin
          state_n  = S_START;
          shreg_n  = tx_data;
          serial_n = 1'b0;
          busy_n   = 1'b1;
`ifdef PIS_PARITY_EN
          parity_n = ^tx_data;
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_n    = '0;
          state_n  = S_DATA;
          serial_n = shreg[0];
          shreg_n  = shreg >> 1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          if (bit_cnt == B_LAST) begin
            bit_cnt_n = '0;
`ifdef PIS_PARITY_EN
            state_n  = S_PARITY;
            serial_n = parity;
`else
            state_n  = S_STOP;
            serial_n = 1'b1;
`endif
          end else begin
            // Shift register already holds the next bit in its LSB.
            bit_cnt_n = bit_cnt + 1'b1;
            serial_n  = shreg[0];
            shreg_n   = shreg >> 1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`ifdef PIS_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          cnt_n    = '0;
          state_n  = S_STOP;
          serial_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          cnt_n    = '0;
          state_n  = S_IDLE;
          serial_n = 1'b1;
          busy_n   = 1'b0;
          done_n   = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n  = S_IDLE;
        serial_n = 1'b1;
        busy_n   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_serial_tx.sv
// Bench for piso_serial_tx: a frame-level model checks two instances (C=4 and C=1) every cycle,
// plus literal line patterns for directed frames. Honours PIS_PARITY_EN.
module tb_piso_serial_tx;

`ifdef PIS_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       tv0 = 1'b0, tv1 = 1'b0;
  logic [7:0] td0 = 8'h00, td1 = 8'h00;
  logic       rdy0, ser0, busy0, done0;
  logic       rdy1, ser1, busy1, done1;

  int total = 0;
  int bad   = 0;

  piso_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut0 (
    .clk(clk), .rst(rst), .tx_data(td0), .tx_valid(tv0),
    .tx_ready(rdy0), .tx_serial(ser0), .tx_busy(busy0), .tx_done(done0)
  );

  piso_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .tx_data(td1), .tx_valid(tv1),
    .tx_ready(rdy1), .tx_serial(ser1), .tx_busy(busy1), .tx_done(done1)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int cpb(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic logic g_ser(input int d);
    return (d == 0) ? ser0 : ser1;
  endfunction
  function automatic logic g_busy(input int d);
    return (d == 0) ? busy0 : busy1;
  endfunction
  function automatic logic g_done(input int d);
    return (d == 0) ? done0 : done1;
  endfunction
  function automatic logic g_rdy(input int d);
    return (d == 0) ? rdy0 : rdy1;
  endfunction

  // frame-level model: position within frame, word captured at accept
  logic       m_act  [2] = '{1'b0, 1'b0};
  logic       m_done [2] = '{1'b0, 1'b0};
  int         m_pos  [2] = '{0, 0};
  logic [7:0] m_word [2] = '{8'h00, 8'h00};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        m_act[d] = 1'b0; m_done[d] = 1'b0; m_pos[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        m_done[d] = 1'b0;
        if (m_act[d]) begin
          m_pos[d]++;
          if (m_pos[d] == FB * cpb(d)) begin
            m_act[d]  = 1'b0;
            m_done[d] = 1'b1;
          end
        end else if ((d == 0) ? tv0 : tv1) begin
          m_act[d]  = 1'b1;
          m_pos[d]  = 0;
          m_word[d] = (d == 0) ? td0 : td1;
        end
      end
    end
  end

  function automatic logic exp_ser(input int d);
    int b;
    if (!m_act[d]) return 1'b1;
    b = m_pos[d] / cpb(d);
    if (b == 0) return 1'b0;
    if (b <= 8) return m_word[d][b-1];
`ifdef PIS_PARITY_EN
    if (b == 9) return ^m_word[d];
`endif
    return 1'b1;
  endfunction

  // per-cycle compare against the model
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      check($sformatf("m_ser%0d", d),  g_ser(d),  exp_ser(d));
      check($sformatf("m_busy%0d", d), g_busy(d), m_act[d]);
      check($sformatf("m_done%0d", d), g_done(d), m_done[d]);
      check($sformatf("m_rdy%0d", d),  g_rdy(d),  !m_act[d] && !rst);
    end
  end

  // driver tasks
  task automatic drive(input int d, input logic v, input logic [7:0] w);
    if (d == 0) begin tv0 = v; td0 = w; end
    else begin tv1 = v; td1 = w; end
  endtask

  // send one word from idle and check the line against a hand-written bit pattern (pat[i] = i-th slot)
  task automatic run_frame(input int d, input logic [7:0] w, input logic [7:0] w_after,
                           input logic [10:0] pat, input string nm);
    int c;
    c = cpb(d);
    @(negedge clk);
    drive(d, 1'b1, w);
    @(negedge clk);
    drive(d, 1'b0, w_after);
    for (int i = 0; i < FB * c; i++) begin
      if (i > 0) @(negedge clk);
      check({nm, "_line"}, g_ser(d), pat[i / c]);
      check({nm, "_busy"}, g_busy(d), 1'b1);
    end
    @(negedge clk);
    check({nm, "_done"}, g_done(d), 1'b1);
    check({nm, "_idle"}, g_busy(d), 1'b0);
    check({nm, "_stopline"}, g_ser(d), 1'b1);
  endtask

  task automatic wait_done0(output int n);
    n = 0;
    while (!done0 && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  logic [10:0] pat;
  int          n;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_ser", ser0, 1'b1);
    check("rst_busy", busy0, 1'b0);
    check("rst_done", done0, 1'b0);
    check("rst_rdy", rdy0, 1'b0);
    #2 rst = 1'b0;
    #1 check("post_rst_rdy", rdy0, 1'b1);

    // 0xA5, C=4
`ifdef PIS_PARITY_EN
    pat = 11'b10101001010;
`else
    pat = 11'b01101001010;
`endif
    run_frame(0, 8'hA5, 8'hA5, pat, "a5");
    repeat (3) @(negedge clk);

    // back-to-back 0xFF then 0x00, valid held high
    @(negedge clk);
    drive(0, 1'b1, 8'hFF);
    @(negedge clk);
    drive(0, 1'b1, 8'h00);
    wait_done0(n);
    check("b2b_len1", n, FB * 4);
    check("b2b_rdy_in_done", rdy0, 1'b1);
    check("b2b_gap_high", ser0, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 8'h00);
    check("b2b_second_start", ser0, 1'b0);
    check("b2b_second_busy", busy0, 1'b1);
    repeat (4) @(negedge clk);
    check("b2b_bit0_zero", ser0, 1'b0);
    wait_done0(n);
    check("b2b_len2", n, FB * 4 - 4);
    repeat (3) @(negedge clk);

    // data change mid-frame must not affect the word in flight
`ifdef PIS_PARITY_EN
    pat = 11'b10100000010;
`else
    pat = 11'b01100000010;
`endif
    run_frame(0, 8'h81, 8'h7E, pat, "x81");
    repeat (FB * 4 + 10) @(negedge clk);
    check("x81_no_second", busy0, 1'b0);

    // async reset mid-frame
    @(negedge clk);
    drive(0, 1'b1, 8'h3C);
    @(negedge clk);
    drive(0, 1'b0, 8'h3C);
    repeat (10) @(negedge clk);
    check("pre_rst_busy", busy0, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst_ser", ser0, 1'b1);
    check("arst_busy", busy0, 1'b0);
    check("arst_rdy", rdy0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1 check("arst_rel_rdy", rdy0, 1'b1);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done0) check("arst_no_done", done0, 1'b0);
    end
    check("arst_idle_line", ser0, 1'b1);

    // C=1, 0x5A
`ifdef PIS_PARITY_EN
    pat = 11'b10010110100;
`else
    pat = 11'b01010110100;
`endif
    run_frame(1, 8'h5A, 8'h5A, pat, "c1_5a");
    repeat (3) @(negedge clk);

`ifdef PIS_PARITY_EN
    // odd data weight -> parity slot high
    pat = 11'b11000000010;
    run_frame(0, 8'h01, 8'h01, pat, "par01");
    repeat (3) @(negedge clk);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    bad++;
    total++;
    $display("FAIL timeout at t=%0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
